// File: rtl/frogger_game_seq.sv
// ============================================================================
// frogger_game_seq : round sequencer (idle/play/dying/scored/game over) with
// lives, score, level and optional round timer (FROGGER_TIMER_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module frogger_game_seq #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 30,
  parameter int unsigned DEATH_FRAMES   = 90,
  parameter int unsigned SCORE_FRAMES   = 45,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned LEVEL_GOALS    = 5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Frame_Tick,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [2:0] o_State,
  output logic       o_Game_Active,
  output logic       o_Frog_Reset,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic [2:0] o_Level,
  output logic [5:0] o_Time_Left
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_DYING  = 3'd2,
    S_SCORED = 3'd3,
    S_OVER   = 3'd4
  } state_e;

  localparam logic [1:0] C_START_LIVES = 2'(START_LIVES);
  localparam logic [2:0] C_GOAL_LAST   = 3'(LEVEL_GOALS - 1);
  localparam logic [7:0] C_DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] C_SCORE_LAST  = 8'(SCORE_FRAMES - 1);
  localparam logic [6:0] C_SCORE_MAX   = 7'd99;
  localparam logic [2:0] C_LEVEL_MAX   = 3'd7;

  state_e     state_q;
  logic [1:0] lives_q;
  logic [6:0] score_q;
  logic [2:0] level_q;
  logic [2:0] goals_q;
  logic [7:0] hold_q;
  logic       frog_reset_q;
  logic       active_q;
  logic       start_q;
  logic       armed_q;

  logic       w_start_edge;
  logic       w_hold_done;
  logic       w_play_entry;
  logic       w_timeout;

  // armed_q blocks a start level that was already high when reset released
  assign w_start_edge = i_Start & ~start_q & armed_q;
  assign w_hold_done  = i_Frame_Tick &
                        (hold_q == ((state_q == S_DYING) ? C_DEATH_LAST : C_SCORE_LAST));
  assign w_play_entry = (((state_q == S_IDLE) || (state_q == S_OVER)) & w_start_edge) |
                        ((state_q == S_DYING) & w_hold_done & (lives_q != 2'd0)) |
                        ((state_q == S_SCORED) & w_hold_done);

`ifdef FROGGER_TIMER_EN
  localparam int unsigned FRAME_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FRAME_W-1:0] C_FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
  localparam logic [5:0]         C_ROUND_SECS = 6'(ROUND_SECONDS);

  logic [5:0]         time_q;
  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      time_q  <= '0;
      frame_q <= '0;
    end else if (w_play_entry) begin
      time_q  <= C_ROUND_SECS;
      frame_q <= '0;
    end else if ((state_q == S_PLAY) && i_Frame_Tick) begin
      if (frame_q == C_FRAME_LAST) begin
        frame_q <= '0;
        if (time_q != 6'd0) time_q <= time_q - 6'd1;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  assign w_timeout   = (state_q == S_PLAY) && (time_q == 6'd0);
  assign o_Time_Left = time_q;
`else
  logic w_unused_timer_cfg;
  assign w_unused_timer_cfg = ^{6'(ROUND_SECONDS), 8'(FRAMES_PER_SEC)};
  assign w_timeout   = 1'b0;
  assign o_Time_Left = 6'd0;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      lives_q      <= '0;
      score_q      <= '0;
      level_q      <= '0;
      goals_q      <= '0;
      hold_q       <= '0;
      frog_reset_q <= 1'b0;
      active_q     <= 1'b0;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      start_q      <= i_Start;
      armed_q      <= armed_q | ~i_Start;
      frog_reset_q <= w_play_entry;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            state_q  <= S_PLAY;
            active_q <= 1'b1;
            lives_q  <= C_START_LIVES;
            score_q  <= '0;
            level_q  <= '0;
            goals_q  <= '0;
          end
        end
        S_PLAY: begin
          // collision outranks timeout, which outranks goal
          if (i_Collision || w_timeout) begin
            state_q  <= S_DYING;
            active_q <= 1'b0;
            hold_q   <= '0;
            if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
          end else if (i_Goal) begin
            state_q  <= S_SCORED;
            active_q <= 1'b0;
            hold_q   <= '0;
            if (score_q != C_SCORE_MAX) score_q <= score_q + 7'd1;
            if (goals_q == C_GOAL_LAST) begin
              goals_q <= '0;
              if (level_q != C_LEVEL_MAX) level_q <= level_q + 3'd1;
            end else begin
              goals_q <= goals_q + 3'd1;
            end
          end
        end
        S_DYING: begin
          if (w_hold_done) begin
            if (lives_q == 2'd0) begin
              state_q <= S_OVER;
            end else begin
              state_q  <= S_PLAY;
              active_q <= 1'b1;
            end
          end else if (i_Frame_Tick) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        S_SCORED: begin
          if (w_hold_done) begin
            state_q  <= S_PLAY;
            active_q <= 1'b1;
          end else if (i_Frame_Tick) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_State       = state_q;
  assign o_Game_Active = active_q;
  assign o_Frog_Reset  = frog_reset_q;
  assign o_Lives       = lives_q;
  assign o_Score       = score_q;
  assign o_Level       = level_q;

endmodule

`default_nettype wire

// File: tb/tb_frogger_game_seq.sv
// ============================================================================
// tb_frogger_game_seq : directed table, timer/reset sequences and random
// stimulus against a behavioural model of the game sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frogger_game_seq;

  localparam int FPS = 4;
  localparam int RS  = 3;
  localparam int DF  = 2;
  localparam int SF  = 2;
  localparam int SL  = 3;
  localparam int LG  = 2;
`ifdef FROGGER_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam int T3 = TIMER ? RS : 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       coll = 1'b0;
  logic       goal = 1'b0;
  logic [2:0] o_State;
  logic       o_Game_Active;
  logic       o_Frog_Reset;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [2:0] o_Level;
  logic [5:0] o_Time_Left;

  frogger_game_seq #(
    .FRAMES_PER_SEC(FPS), .ROUND_SECONDS(RS), .DEATH_FRAMES(DF),
    .SCORE_FRAMES(SF), .START_LIVES(SL), .LEVEL_GOALS(LG)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Frame_Tick(tick),
    .i_Collision(coll), .i_Goal(goal), .o_State(o_State),
    .o_Game_Active(o_Game_Active), .o_Frog_Reset(o_Frog_Reset),
    .o_Lives(o_Lives), .o_Score(o_Score), .o_Level(o_Level),
    .o_Time_Left(o_Time_Left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int m_state, m_lives, m_score, m_level, m_goals, m_hold, m_frames, m_time;
  bit m_prev, m_armed, m_frog;

  function automatic void m_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_level = 0; m_goals = 0;
    m_hold = 0; m_frames = 0; m_time = 0; m_prev = 0; m_armed = 0; m_frog = 0;
  endfunction

  function automatic void m_enter_play();
    m_state  = 1;
    m_frog   = 1;
    m_time   = TIMER ? RS : 0;
    m_frames = 0;
  endfunction

  function automatic void m_step(input bit s, input bit t, input bit c, input bit g);
    bit press;
    bit tout;
    press   = s && !m_prev && m_armed;
    tout    = TIMER && (m_state == 1) && (m_time == 0);
    m_armed = m_armed || !s;
    m_prev  = s;
    m_frog  = 0;
    case (m_state)
      0, 4: if (press) begin
        m_lives = SL; m_score = 0; m_level = 0; m_goals = 0;
        m_enter_play();
      end
      1: begin
        if (TIMER && t) begin
          m_frames++;
          if (m_frames == FPS) begin
            m_frames = 0;
            if (m_time > 0) m_time--;
          end
        end
        if (c || tout) begin
          if (m_lives > 0) m_lives--;
          m_state = 2; m_hold = 0;
        end else if (g) begin
          if (m_score < 99) m_score++;
          m_goals++;
          if (m_goals == LG) begin
            m_goals = 0;
            if (m_level < 7) m_level++;
          end
          m_state = 3; m_hold = 0;
        end
      end
      2: if (t) begin
        m_hold++;
        if (m_hold == DF) begin
          if (m_lives == 0) m_state = 4;
          else m_enter_play();
        end
      end
      3: if (t) begin
        m_hold++;
        if (m_hold == SF) m_enter_play();
      end
      default: m_state = 0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("m_state", int'(o_State), m_state);
    chk("m_active", int'(o_Game_Active), (m_state == 1) ? 1 : 0);
    chk("m_frog_reset", int'(o_Frog_Reset), int'(m_frog));
    chk("m_lives", int'(o_Lives), m_lives);
    chk("m_score", int'(o_Score), m_score);
    chk("m_level", int'(o_Level), m_level);
    chk("m_time_left", int'(o_Time_Left), m_time);
  endtask

  task automatic cyc(input bit s, input bit t, input bit c, input bit g);
    start = s; tick = t; coll = c; goal = g;
    @(posedge clk);
    m_step(s, t, c, g);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    start = 0; tick = 0; coll = 0; goal = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    chk("rst_state", int'(o_State), 0);
    chk("rst_active", int'(o_Game_Active), 0);
    chk("rst_lives", int'(o_Lives), 0);
    chk("rst_time", int'(o_Time_Left), 0);
  endtask

  typedef struct {
    bit s, t, c, g;
    int st, lv, sc, lvl, fr, tm;
  } vec_t;

  vec_t tbl[27];

  initial begin
    tbl[0]  = '{0,0,0,0, 0,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0, 1,3,0,0,1,T3};
    tbl[2]  = '{1,0,0,0, 1,3,0,0,0,T3};
    tbl[3]  = '{0,0,1,1, 2,2,0,0,0,T3};
    tbl[4]  = '{0,1,0,0, 2,2,0,0,0,T3};
    tbl[5]  = '{0,0,0,0, 2,2,0,0,0,T3};
    tbl[6]  = '{0,1,0,0, 1,2,0,0,1,T3};
    tbl[7]  = '{0,0,0,1, 3,2,1,0,0,T3};
    tbl[8]  = '{0,1,0,0, 3,2,1,0,0,T3};
    tbl[9]  = '{0,1,0,0, 1,2,1,0,1,T3};
    tbl[10] = '{0,0,0,1, 3,2,2,1,0,T3};
    tbl[11] = '{0,1,1,0, 3,2,2,1,0,T3};
    tbl[12] = '{0,1,0,0, 1,2,2,1,1,T3};
    tbl[13] = '{0,0,0,1, 3,2,3,1,0,T3};
    tbl[14] = '{0,1,0,0, 3,2,3,1,0,T3};
    tbl[15] = '{0,1,0,0, 1,2,3,1,1,T3};
    tbl[16] = '{0,0,0,1, 3,2,4,2,0,T3};
    tbl[17] = '{0,1,0,0, 3,2,4,2,0,T3};
    tbl[18] = '{0,1,0,0, 1,2,4,2,1,T3};
    tbl[19] = '{0,0,1,0, 2,1,4,2,0,T3};
    tbl[20] = '{0,1,0,0, 2,1,4,2,0,T3};
    tbl[21] = '{0,1,0,0, 1,1,4,2,1,T3};
    tbl[22] = '{0,0,1,0, 2,0,4,2,0,T3};
    tbl[23] = '{0,1,0,0, 2,0,4,2,0,T3};
    tbl[24] = '{0,1,0,0, 4,0,4,2,0,T3};
    tbl[25] = '{1,1,0,0, 1,3,0,0,1,T3};
    tbl[26] = '{0,0,0,0, 1,3,0,0,0,T3};

    do_reset();

    // directed table
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].s, tbl[i].t, tbl[i].c, tbl[i].g);
      chk("tbl_state", int'(o_State), tbl[i].st);
      chk("tbl_active", int'(o_Game_Active), (tbl[i].st == 1) ? 1 : 0);
      chk("tbl_lives", int'(o_Lives), tbl[i].lv);
      chk("tbl_score", int'(o_Score), tbl[i].sc);
      chk("tbl_level", int'(o_Level), tbl[i].lvl);
      chk("tbl_frog_reset", int'(o_Frog_Reset), tbl[i].fr);
      chk("tbl_time", int'(o_Time_Left), tbl[i].tm);
    end

    // round timer: 12 ticks in PLAY with no events
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 1, 0, 0);
      chk("timer_left", int'(o_Time_Left), TIMER ? (RS - k / FPS) : 0);
      chk("timer_state", int'(o_State), 1);
    end
    cyc(0, 0, 0, 0);
    chk("timeout_state", int'(o_State), TIMER ? 2 : 1);
    chk("timeout_lives", int'(o_Lives), TIMER ? 2 : 3);

    // asynchronous reset while SCORED with score 5, start held through release
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1);
      if (k < 4) begin
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
      end
    end
    chk("pre_rst_state", int'(o_State), 3);
    chk("pre_rst_score", int'(o_Score), 5);
    #2;
    rst = 1;
    start = 1;
    #1;
    chk("async_state", int'(o_State), 0);
    chk("async_score", int'(o_Score), 0);
    chk("async_level", int'(o_Level), 0);
    chk("async_lives", int'(o_Lives), 0);
    chk("async_frog", int'(o_Frog_Reset), 0);
    chk("async_time", int'(o_Time_Left), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      chk("held_start_state", int'(o_State), 0);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("restart_state", int'(o_State), 1);
    chk("restart_frog", int'(o_Frog_Reset), 1);

    // randomized stimulus against the model
    do_reset();
    begin
      bit s;
      s = 0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(5) == 0) s = ~s;
        cyc(s, $urandom_range(2) == 0, $urandom_range(24) == 0, $urandom_range(7) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
